// File: rtl/block_fetch_memory_if.sv
// Request/response bundle for block_fetch_memory.
// master: the requester. It drives the request, invalidate and responseReady.
// slave : the memory. It drives requestReady and the response fields.
// Signals:
//   requestValid/requestAddress/requestReady : fetch request handshake
//   invalidate                               : discard the buffered block
//   responseValid/responseReady              : response handshake
//   responseData/responseError/responseHit   : response payload
interface block_fetch_memory_if #(
  parameter int unsigned WORDS_PER_BLOCK = 4
) ();
  localparam int unsigned DataWidth = 32 * WORDS_PER_BLOCK;

  logic                 requestValid;
  logic [31:0]          requestAddress;
  logic                 requestReady;
  logic                 invalidate;
  logic                 responseValid;
  logic                 responseReady;
  logic [DataWidth-1:0] responseData;
  logic                 responseError;
  logic                 responseHit;

  modport master (
    output requestValid, requestAddress, invalidate, responseReady,
    input  requestReady, responseValid, responseData, responseError, responseHit
  );

  modport slave (
    input  requestValid, requestAddress, invalidate, responseReady,
    output requestReady, responseValid, responseData, responseError, responseHit
  );
endinterface

// File: rtl/block_fetch_memory.sv
// Read-only block fetch memory with a single-entry block buffer.
// A request for a buffered block is answered one edge after acceptance.
// A miss waits LATENCY edges, reads the ROM, and refills the buffer.
// The ROM holds byte i = i[7:0].
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : block_fetch_memory_if slave modport (request/response/invalidate)
module block_fetch_memory #(
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned DEPTH_BYTES     = 1024,
  parameter int unsigned LATENCY         = 4
) (
  input  logic              clock,
  input  logic              reset,
  block_fetch_memory_if.slave bus
);
  localparam int unsigned BlockBytes = 4 * WORDS_PER_BLOCK;
  localparam int unsigned DataW      = 8 * BlockBytes;
  localparam int unsigned AddrW      = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CntLoad    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // Constant ROM contents: byte i holds i[7:0].
  logic [7:0] rom [DEPTH_BYTES];
  for (genvar i = 0; i < int'(DEPTH_BYTES); i++) begin : g_rom
    assign rom[i] = 8'(i);
  end

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      base_q, base_d;
  logic             buf_valid_q, buf_valid_d;
  logic [31:0]      tag_q, tag_d;
  logic [DataW-1:0] buf_data_q, buf_data_d;
  logic [DataW-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_hit_q, resp_hit_d;

  logic [31:0]      req_base;
  logic             req_hit;
  logic             base_oor;
  logic [DataW-1:0] fill_data;

  assign req_base = bus.requestAddress & ~(32'(BlockBytes) - 32'd1);
  assign req_hit  = buf_valid_q && (tag_q == req_base) && !bus.invalidate;
  // Any address bit at or above the memory size puts the block out of range.
  assign base_oor = |base_q[31:AddrW];

  // Block read from the latched base; base is block aligned, so OR-ing the offset is an add.
  always_comb begin
    fill_data = '0;
    for (int b = 0; b < int'(BlockBytes); b++) begin
      fill_data[8*b +: 8] = rom[base_q[AddrW-1:0] | AddrW'(b)];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    buf_valid_d = buf_valid_q;
    tag_d       = tag_q;
    buf_data_d  = buf_data_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    resp_hit_d  = resp_hit_q;

    // Invalidate applies on any edge; a refill below overrides it.
    if (bus.invalidate) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.requestValid) begin
          if (req_hit) begin
            state_d     = StResp;
            resp_data_d = buf_data_q;
            resp_err_d  = 1'b0;
            resp_hit_d  = 1'b1;
          end else begin
            state_d = StWait;
            base_d  = req_base;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // The accept edge counts as the first; the counter reaching 0 is the LATENCY-th edge.
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          resp_hit_d = 1'b0;
          if (base_oor) begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end else begin
            resp_data_d = fill_data;
            resp_err_d  = 1'b0;
            buf_valid_d = 1'b1;
            tag_d       = base_q;
            buf_data_d  = fill_data;
          end
        end
      end
      StResp: begin
        if (bus.responseReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      base_q      <= '0;
      buf_valid_q <= 1'b0;
      tag_q       <= '0;
      buf_data_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      resp_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      buf_valid_q <= buf_valid_d;
      tag_q       <= tag_d;
      buf_data_q  <= buf_data_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      resp_hit_q  <= resp_hit_d;
    end
  end

  assign bus.requestReady  = (state_q == StIdle);
  assign bus.responseValid = (state_q == StResp);
  assign bus.responseData  = resp_data_q;
  assign bus.responseError = resp_err_q;
  assign bus.responseHit   = resp_hit_q;

  // A stalled response must hold its payload.
  a_resp_stable: assert property (@(posedge clock) disable iff (reset)
    bus.responseValid && !bus.responseReady |=>
      bus.responseValid && $stable(bus.responseData) && $stable(bus.responseError)
      && $stable(bus.responseHit));
endmodule

// File: tb/tb_block_fetch_memory.sv
module tb_block_fetch_memory;
  localparam logic [127:0] Blk20 = 128'h2F2E2D2C_2B2A2928_27262524_23222120;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  block_fetch_memory_if #(.WORDS_PER_BLOCK(4)) bus ();

  block_fetch_memory #(
    .WORDS_PER_BLOCK(4),
    .DEPTH_BYTES    (1024),
    .LATENCY        (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         inval;       // invalidate on the accept edge
    logic         inval_fill;  // invalidate on the miss-completion edge
    int           hold;        // cycles to hold responseReady low
    logic         exp_hit;
    logic         exp_err;
    int           exp_lat;
    logic [127:0] exp_data;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic         err;
    logic         hit;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference block contents: byte at base+b is (base+b)[7:0]; out of range reads zero.
  function automatic logic [127:0] ref_block(input logic [31:0] addr);
    logic [127:0] r = '0;
    logic [31:0]  base = addr & 32'hFFFF_FFF0;
    if (base < 32'd1024) begin
      for (int b = 0; b < 16; b++) r[8*b +: 8] = 8'(base + 32'(b));
    end
    return r;
  endfunction

  // Called #1 after a clock edge with the DUT idle.
  task automatic run_req(input vec_t v, input string tag);
    exp_t         e;
    exp_t         got;
    int           n;
    logic [127:0] d0;
    check({tag, " ready"}, 128'(bus.requestReady), 128'(1));
    bus.requestValid   = 1'b1;
    bus.requestAddress = v.addr;
    bus.invalidate     = v.inval;
    bus.responseReady  = 1'b0;
    @(posedge clock); #1;
    bus.requestValid   = 1'b0;
    bus.invalidate     = 1'b0;
    bus.requestAddress = $urandom();
    e.data = v.exp_data; e.err = v.exp_err; e.hit = v.exp_hit; e.lat = v.exp_lat;
    sb.push_back(e);
    n = 1;
    while (!bus.responseValid && n < 20) begin
      if (v.inval_fill && n == v.exp_lat - 1) bus.invalidate = 1'b1;
      @(posedge clock); #1;
      bus.invalidate     = 1'b0;
      bus.requestAddress = $urandom();
      n++;
    end
    got = sb.pop_front();
    check({tag, " latency"}, 128'(n), 128'(got.lat));
    check({tag, " data"}, bus.responseData, got.data);
    check({tag, " error"}, 128'(bus.responseError), 128'(got.err));
    check({tag, " hit"}, 128'(bus.responseHit), 128'(got.hit));
    d0 = bus.responseData;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clock); #1;
      bus.requestAddress = $urandom();
      check({tag, " hold data"}, bus.responseData, d0);
      check({tag, " hold valid/ready"}, 128'({bus.responseValid, bus.requestReady}),
            128'(2'b10));
    end
    bus.responseReady = 1'b1;
    @(posedge clock); #1;
    bus.responseReady = 1'b0;
    check({tag, " back to idle"}, 128'({bus.responseValid, bus.requestReady}), 128'(2'b01));
  endtask

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{32'h0000_0023, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4, Blk20};
    vecs[1]  = '{32'h0000_002C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, Blk20};
    vecs[2]  = '{32'h0000_0100, 1'b0, 1'b0, 3, 1'b0, 1'b0, 4, ref_block(32'h100)};
    vecs[3]  = '{32'h0000_0400, 1'b0, 1'b0, 0, 1'b0, 1'b1, 4, 128'h0};
    vecs[4]  = '{32'h0000_0100, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, ref_block(32'h100)};
    vecs[5]  = '{32'h0000_0104, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4, ref_block(32'h100)};
    vecs[6]  = '{32'h8000_0108, 1'b0, 1'b0, 1, 1'b0, 1'b1, 4, 128'h0};
    vecs[7]  = '{32'h0000_010C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, ref_block(32'h100)};
    vecs[8]  = '{32'h0000_0200, 1'b0, 1'b1, 0, 1'b0, 1'b0, 4, ref_block(32'h200)};
    vecs[9]  = '{32'h0000_0204, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, ref_block(32'h200)};
    vecs[10] = '{32'h0000_03F5, 1'b0, 1'b0, 2, 1'b0, 1'b0, 4, ref_block(32'h3F0)};

    reset              = 1'b1;
    bus.requestValid   = 1'b0;
    bus.requestAddress = '0;
    bus.invalidate     = 1'b0;
    bus.responseReady  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset ready", 128'(bus.requestReady), 128'(1));
    check("reset valid", 128'(bus.responseValid), 128'(0));
    check("reset data", bus.responseData, 128'h0);
    check("reset err/hit", 128'({bus.responseError, bus.responseHit}), 128'(0));

    for (int i = 0; i < 11; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a miss drops it and empties the buffer.
    bus.requestValid   = 1'b1;
    bus.requestAddress = 32'h0000_0000;
    @(posedge clock); #1;
    bus.requestValid  = 1'b0;
    bus.responseReady = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset ready", 128'(bus.requestReady), 128'(1));
    check("midreset data", bus.responseData, 128'h0);
    check("midreset err/hit", 128'({bus.responseError, bus.responseHit}), 128'(0));
    for (int i = 0; i < 6; i++) begin
      check("midreset no valid", 128'(bus.responseValid), 128'(0));
      @(posedge clock); #1;
    end
    bus.responseReady = 1'b0;
    v = '{32'h0000_03F8, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4, ref_block(32'h3F0)};
    run_req(v, "post-reset 3F8");
    v = '{32'h0000_0020, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4, Blk20};
    run_req(v, "post-reset 20");

    check("scoreboard drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
